// File: rtl/uart_tx_arbiter_if.sv
// Byte-channel bundle between the frame builder / uart_rx echo path and uart_tx.
// master drives frame/echo bytes and tx readiness; slave is the arbiter.
interface uart_tx_arbiter_if;
  logic [7:0] frm_data;
  logic       frm_valid;
  logic       frm_last;
  logic       frm_ready;
  logic [7:0] echo_data;
  logic       echo_valid;
  logic [7:0] tx_data;
  logic       tx_data_valid;
  logic       tx_data_ready;

  modport master (
    output frm_data, frm_valid, frm_last, echo_data, echo_valid, tx_data_ready,
    input  frm_ready, tx_data, tx_data_valid
  );

  modport slave (
    input  frm_data, frm_valid, frm_last, echo_data, echo_valid, tx_data_ready,
    output frm_ready, tx_data, tx_data_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Shares uart_tx between atomic telemetry frames and FIFO-buffered echo bytes; 1-cycle grant, registered tx output.
// tx_data held while uart_tx stalls; frames backpressured via frm_ready, echo drops counted when the FIFO is full.
module uart_tx_arbiter #(
  parameter int ECHO_DEPTH = 16,
  parameter int ECHO_BURST = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  uart_tx_arbiter_if.slave  bus,
  output logic              echo_overflow,
  output logic [7:0]        drop_cnt,
  output logic              busy
);
  localparam int AW = $clog2(ECHO_DEPTH);
  localparam int BW = $clog2(ECHO_BURST + 1);
  localparam logic [AW:0]   PTR_ONE   = 1;
  localparam logic [BW-1:0] BURST_ONE = 1;
  localparam logic [BW-1:0] BURST_END = BW'(ECHO_BURST - 1);

  typedef enum logic [1:0] {IDLE, FRAME, ECHO} state_t;
  typedef enum logic {GNT_FRAME, GNT_ECHO} grant_t;

  state_t        state;
  grant_t        last_grant;
  logic [BW-1:0] burst_cnt;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [7:0]    mem [ECHO_DEPTH];
  logic [7:0]    tx_data_q;
  logic          tx_vld_q;

  logic fifo_empty, fifo_full, slot_free, pop, push, drop;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign slot_free  = !tx_vld_q || bus.tx_data_ready;
  assign pop        = (state == ECHO) && slot_free && !fifo_empty;
  // A same-cycle pop frees a slot, so a push into a full FIFO still lands.
  assign push       = bus.echo_valid && (!fifo_full || pop);
  assign drop       = bus.echo_valid && fifo_full && !pop;

  assign bus.frm_ready     = (state == FRAME) && slot_free;
  assign bus.tx_data       = tx_data_q;
  assign bus.tx_data_valid = tx_vld_q;
  assign busy              = (state != IDLE) || tx_vld_q;

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= bus.echo_data;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state         <= IDLE;
      last_grant    <= GNT_ECHO;
      burst_cnt     <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      tx_data_q     <= '0;
      tx_vld_q      <= 1'b0;
      echo_overflow <= 1'b0;
      drop_cnt      <= '0;
    end else begin
      if (bus.tx_data_ready) tx_vld_q <= 1'b0;
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      echo_overflow <= drop;
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;

      unique case (state)
        IDLE: begin
          if (bus.frm_valid && (fifo_empty || last_grant == GNT_ECHO)) state <= FRAME;
          else if (!fifo_empty)                                        state <= ECHO;
        end
        FRAME: begin
          // Stays here until the last byte, however long frm_valid is low.
          if (bus.frm_valid && slot_free) begin
            tx_data_q <= bus.frm_data;
            tx_vld_q  <= 1'b1;
            if (bus.frm_last) begin
              last_grant <= GNT_FRAME;
              state      <= IDLE;
            end
          end
        end
        ECHO: begin
          if (pop) begin
            tx_data_q <= mem[rd_ptr[AW-1:0]];
            tx_vld_q  <= 1'b1;
            rd_ptr    <= rd_ptr + PTR_ONE;
            if (burst_cnt == BURST_END) begin
              state      <= IDLE;
              last_grant <= GNT_ECHO;
              burst_cnt  <= '0;
            end else begin
              burst_cnt <= burst_cnt + BURST_ONE;
            end
          end else if (fifo_empty && slot_free) begin
            state      <= IDLE;
            last_grant <= GNT_ECHO;
            burst_cnt  <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: expected tx bytes queued in predicted arbitration order.
module tb_uart_tx_arbiter;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  uart_tx_arbiter_if u_if();
  logic       echo_overflow;
  logic [7:0] drop_cnt;
  logic       busy;

  uart_tx_arbiter #(.ECHO_DEPTH(16), .ECHO_BURST(4)) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .bus           (u_if),
    .echo_overflow (echo_overflow),
    .drop_cnt      (drop_cnt),
    .busy          (busy)
  );

  typedef logic [7:0] byte_q_t [$];

  logic [7:0] exp_q [$];
  int         n_cmp   = 0;
  int         n_err   = 0;
  int         ov_cnt  = 0;
  int         acc_cnt = 0;
  int         rdy_mode = 1;   // 0: stalled, 1: always ready, 2: ready 1 of 3
  int         cyc = 0;
  bit         sb_en = 1'b1;
  bit         held_v = 1'b0;
  logic [7:0] held_d = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial begin
    u_if.tx_data_ready = 1'b1;
    forever begin
      @(posedge sys_clk); #1;
      cyc++;
      case (rdy_mode)
        0:       u_if.tx_data_ready = 1'b0;
        1:       u_if.tx_data_ready = 1'b1;
        default: u_if.tx_data_ready = (cyc % 3 == 0);
      endcase
    end
  end

  // Monitor: scoreboard pop, stall stability and overflow pulse counting.
  initial begin
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        held_v = 1'b0;
      end else begin
        if (held_v && u_if.tx_data_valid) check_eq("stall_hold", 32'(u_if.tx_data), 32'(held_d));
        if (sb_en && u_if.tx_data_valid && u_if.tx_data_ready) begin
          if (exp_q.size() == 0) check_eq("sb_extra_byte", 32'(u_if.tx_data), 32'h100);
          else                   check_eq("sb_byte", 32'(u_if.tx_data), 32'(exp_q.pop_front()));
        end
        if (echo_overflow) ov_cnt++;
        held_v = u_if.tx_data_valid && !u_if.tx_data_ready;
        held_d = u_if.tx_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d bytes outstanding", exp_q.size());
    $fatal(1);
  end

  task automatic drive_frame(input byte_q_t b);
    int t;
    bit acc;
    for (int i = 0; i < b.size(); i++) begin
      u_if.frm_data  = b[i];
      u_if.frm_last  = (i == b.size() - 1);
      u_if.frm_valid = 1'b1;
      acc = 1'b0;
      t   = 0;
      while (!acc) begin
        @(negedge sys_clk);
        if (!sys_rst_n) begin
          u_if.frm_valid = 1'b0; u_if.frm_last = 1'b0; return;
        end
        acc = u_if.frm_ready;
        @(posedge sys_clk); #1;
        if (!sys_rst_n) begin
          u_if.frm_valid = 1'b0; u_if.frm_last = 1'b0; return;
        end
        if (acc) acc_cnt++;
        t++;
        if (!acc && t > 2000) begin
          check_eq("frm_accept_timeout", 32'(t), 32'd0);
          u_if.frm_valid = 1'b0; u_if.frm_last = 1'b0; return;
        end
      end
    end
    u_if.frm_valid = 1'b0;
    u_if.frm_last  = 1'b0;
  endtask

  task automatic push_echo(input logic [7:0] d);
    u_if.echo_data  = d;
    u_if.echo_valid = 1'b1;
    @(posedge sys_clk); #1;
    u_if.echo_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while (exp_q.size() != 0 && t < budget) begin
      @(posedge sys_clk); t++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(posedge sys_clk);
    #1;
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("idle_frm_ready", 32'(u_if.frm_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tx_data"},       32'(u_if.tx_data),       32'd0);
    check_eq({tag, "_tx_data_valid"}, 32'(u_if.tx_data_valid), 32'd0);
    check_eq({tag, "_frm_ready"},     32'(u_if.frm_ready),     32'd0);
    check_eq({tag, "_echo_overflow"}, 32'(echo_overflow),      32'd0);
    check_eq({tag, "_drop_cnt"},      32'(drop_cnt),           32'd0);
    check_eq({tag, "_busy"},          32'(busy),               32'd0);
  endtask

  task automatic do_reset();
    @(posedge sys_clk); #2;
    sys_rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
  endtask

  initial begin
    byte_q_t fa, fb, fc;
    int t;
    u_if.frm_data = '0; u_if.frm_valid = 1'b0; u_if.frm_last = 1'b0;
    u_if.echo_data = '0; u_if.echo_valid = 1'b0;
    #12 check_reset_outputs("por");
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    repeat (2) @(posedge sys_clk); #1;

    // Single 16-byte telemetry frame
    fa = {8'hFF, 8'h00, 8'h00, 8'hFF, 8'h0A, 8'h5C, 8'hFF, 8'h00,
          8'h00, 8'h00, 8'h00, 8'hFF, 8'h07, 8'hD0, 8'hFF, 8'h00};
    foreach (fa[i]) exp_q.push_back(fa[i]);
    drive_frame(fa);
    wait_drain(200);

    // Echo during a frame, second frame pending: frame, burst of 4, frame, remainder
    fb = {};
    for (int k = 0; k < 4; k++) fb.push_back(8'(8'hB0 + k));
    foreach (fa[i]) exp_q.push_back(fa[i]);
    for (int k = 0; k < 4; k++) exp_q.push_back(8'(8'h41 + k));
    foreach (fb[i]) exp_q.push_back(fb[i]);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h46);
    fork
      begin drive_frame(fa); drive_frame(fb); end
      begin
        repeat (4) @(posedge sys_clk);
        #1;
        for (int k = 0; k < 6; k++) push_echo(8'(8'h41 + k));
      end
    join
    wait_drain(300);

    // Tie on first grant after reset, then again after an echo grant
    do_reset();
    exp_q.push_back(8'hD0); exp_q.push_back(8'hD1); exp_q.push_back(8'hE0);
    fork
      drive_frame({8'hD0, 8'hD1});
      push_echo(8'hE0);
    join
    wait_drain(100);
    exp_q.push_back(8'hD2); exp_q.push_back(8'hD3); exp_q.push_back(8'hE1);
    fork
      drive_frame({8'hD2, 8'hD3});
      push_echo(8'hE1);
    join
    wait_drain(100);

    // Overflow while uart_tx is stalled inside a frame
    rdy_mode = 0;
    repeat (2) @(posedge sys_clk); #1;
    ov_cnt = 0;
    exp_q.push_back(8'h90); exp_q.push_back(8'h91);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(k));
    fork
      drive_frame({8'h90, 8'h91});
      begin
        repeat (3) @(posedge sys_clk);
        #1;
        for (int k = 0; k < 20; k++) push_echo(8'(k));
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("ovf_pulses", 32'(ov_cnt), 32'd4);
        check_eq("ovf_drop_cnt", 32'(drop_cnt), 32'd4);
        for (int k = 0; k < 300; k++) push_echo(8'hAA);
        repeat (2) @(posedge sys_clk);
        #1;
        check_eq("ovf_drop_sat", 32'(drop_cnt), 32'd255);
        check_eq("ovf_pulses_total", 32'(ov_cnt), 32'd304);
        rdy_mode = 1;
      end
    join
    wait_drain(300);

    // Backpressure 1-of-3 across a frame and an echo burst
    rdy_mode = 2;
    fc = {};
    for (int k = 0; k < 8; k++) fc.push_back(8'(8'h30 + k));
    foreach (fc[i]) exp_q.push_back(fc[i]);
    for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h60 + k));
    fork
      drive_frame(fc);
      begin
        repeat (3) @(posedge sys_clk);
        #1;
        for (int k = 0; k < 5; k++) push_echo(8'(8'h60 + k));
      end
    join
    wait_drain(400);
    rdy_mode = 1;
    repeat (2) @(posedge sys_clk); #1;

    // Mid-frame reset with echo bytes queued
    sb_en = 1'b0;
    acc_cnt = 0;
    fc = {};
    for (int k = 0; k < 16; k++) fc.push_back(8'(8'h70 + k));
    fork
      drive_frame(fc);
      begin
        repeat (2) @(posedge sys_clk);
        #1;
        for (int k = 0; k < 3; k++) push_echo(8'(8'hF1 + k));
        t = 0;
        while (acc_cnt < 4 && t < 100) begin
          @(posedge sys_clk); #1; t++;
        end
        check_eq("midrst_reach_byte5", 32'(acc_cnt >= 4), 32'd1);
        @(posedge sys_clk); #2;
        sys_rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
      end
    join
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    sb_en = 1'b1;
    repeat (10) @(posedge sys_clk);
    #1;
    check_eq("post_rst_fifo_empty_busy", 32'(busy), 32'd0);
    check_eq("post_rst_tx_valid", 32'(u_if.tx_data_valid), 32'd0);
    foreach (fc[i]) exp_q.push_back(fc[i]);
    drive_frame(fc);
    wait_drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the single `uart_tx` byte channel between two requesters: a packetized telemetry-frame source (ADC voltage frames) and a UART echo path fed by `uart_rx`. Frames are atomic: no echo byte is ever inserted inside a frame. Echo bytes are buffered in an internal FIFO and drained in bounded bursts between frames. The block sits between the frame builder / `uart_rx` and the `uart_tx` instance, replacing direct muxing of `tx_data`.

## Interface
- `ECHO_DEPTH`, 16: echo FIFO depth in bytes; power of two, ≥ 2.
- `ECHO_BURST`, 4: maximum echo bytes granted per echo turn; ≥ 1.
- `sys_clk  in  1`: system clock (100 MHz).
- `sys_rst_n  in  1`: reset, asynchronous, active-low. Clock is `sys_clk`.
- `frm_data  in  8`: frame byte.
- `frm_valid  in  1`: frame byte valid. Held with data stable until accepted.
- `frm_last  in  1`: marks the final byte of a frame. Qualified by `frm_valid`.
- `frm_ready  out  1`: frame byte accepted when `frm_valid & frm_ready`.
- `echo_data  in  8`: received byte to echo.
- `echo_valid  in  1`: single-cycle strobe. There is no backpressure on this port.
- `echo_overflow  out  1`: one-cycle pulse when an echo byte is dropped.
- `drop_cnt  out  8`: count of dropped echo bytes; saturates at 255.
- `tx_data  out  8`: byte to `uart_tx`.
- `tx_data_valid  out  1`: byte valid toward `uart_tx`.
- `tx_data_ready  in  1`: `uart_tx` ready. A transfer occurs on `tx_data_valid & tx_data_ready`.
- `busy  out  1`: high whenever the state is not IDLE or `tx_data_valid` is high.

## Operation
- **Output register.** `tx_data` and `tx_data_valid` are registered. The slot is free when `!tx_data_valid | tx_data_ready`. While `tx_data_valid & !tx_data_ready`, `tx_data` is held stable.
- **FSM states:** IDLE, FRAME, ECHO.
- **IDLE → FRAME** when `frm_valid` is high and either the FIFO is empty or `last_grant == ECHO`.
- **IDLE → ECHO** when the FIFO is non-empty and either `frm_valid` is low or `last_grant == FRAME`.
- **Grant tie-break.** When both requesters are pending, the grant goes to the requester that was not granted last. `last_grant` resets to ECHO, so a frame wins the first tie.
- **FRAME state.**
  - `frm_ready = (state == FRAME) & slot_free`. This is combinational.
  - Each accepted byte loads the output register.
  - Accepting a byte with `frm_last = 1` sets `last_grant = FRAME` and moves to IDLE on the next cycle.
  - Echo pushes continue into the FIFO throughout.
- **ECHO state.**
  - When the slot is free and the FIFO is non-empty, the FIFO head is popped into the output register and `burst_cnt` increments.
  - The state exits to IDLE when a pop makes `burst_cnt == ECHO_BURST`, or when the FIFO is empty with the slot free. On exit, `last_grant = ECHO` and `burst_cnt` clears.
  - `frm_ready` is 0 in this state.
- **FIFO.**
  - Read and write pointers are `log2(ECHO_DEPTH)+1` bits wide and wrap modulo 2·`ECHO_DEPTH`.
  - Full is defined as MSBs differing with the LSBs equal; empty is defined as the pointers being equal.
  - Push on `echo_valid`. Pop only in ECHO state.
- **Full boundary.**
  - A push while full with no pop in the same cycle drops the byte, pulses `echo_overflow`, and increments `drop_cnt` (saturating).
  - A push and a pop in the same cycle while full both succeed, and the occupancy is unchanged.
  - A push while empty is not visible to a same-cycle pop; the FIFO has no fall-through.
- **Frame boundary.** A frame whose `frm_valid` drops mid-frame keeps FRAME state indefinitely; a grant never preempts a frame.
- **Reset (asynchronous, including mid-operation).**
  - State returns to IDLE and both FIFO pointers clear, so the FIFO contents are discarded.
  - `tx_data = 0`, `tx_data_valid = 0`, `frm_ready = 0`, `echo_overflow = 0`, `drop_cnt = 0`, `busy = 0`.

## Timing
- **IDLE → grant state:** 1 cycle.
- **Frame path.** The first frame byte is accepted no earlier than the cycle after entering FRAME. `tx_data_valid` rises the cycle after acceptance.
- **Echo path.** The first echo byte pops in the first ECHO cycle, and `tx_data_valid` is high the next cycle.
- **Minimum echo latency:** from `echo_valid` on an empty FIFO with the arbiter in IDLE to `tx_data_valid`, 3 cycles (push, grant, pop).
- **Throughput.** With `tx_data_ready` held high, one byte per cycle is transferred within a grant, with no bubble between consecutive bytes. There is one IDLE cycle between grants.
- **Overflow timing.** `echo_overflow` is asserted in the cycle after the dropped strobe, coincident with the `drop_cnt` update.

## Test plan
- **Single frame.** Drive a 16-byte frame (FF 00 00 FF 0A 5C FF 00 00 00 00 FF 07 D0 FF 00, last on byte 16) with `tx_data_ready` held high and no echo traffic. Expect exactly those 16 bytes in order on `tx_data`, `frm_ready` never asserted outside FRAME, and a return to IDLE after the last byte.
- **Echo during a frame.** Inject 6 echo bytes (0x41..0x46) during frame byte 3. Expect the frame to complete uninterrupted, then 0x41..0x44 (one burst, `ECHO_BURST` = 4). If a second frame is pending, expect it next, then 0x45, 0x46.
- **Tie on first grant.** After reset, assert `frm_valid` and an echo strobe in the same cycle. The FIFO byte is visible one cycle later, so the frame is granted first. Repeat with both pending in IDLE after an ECHO grant: the frame still wins.
- **Overflow.** Hold `tx_data_ready` = 0 inside a frame and push 20 echo bytes. Expect 4 `echo_overflow` pulses, `drop_cnt` = 4, and the first 16 bytes preserved in order. Push 300 further drops and expect `drop_cnt` = 255.
- **Backpressure.** Toggle `tx_data_ready` on a 1-of-3 pattern during a frame and an echo burst. Expect `tx_data` stable while stalled, and no byte lost or duplicated.
- **Mid-frame reset.** Assert `sys_rst_n` low at byte 5 of a frame with 3 echo bytes queued. Expect all outputs at their reset values immediately, the FIFO empty after release, and a subsequent frame sent completely from byte 1.
